// File: rtl/i2c_tmp101_read_sequencer.sv
// Transaction controller for the I2C datapath: runs one complete TMP101
// temperature read (START, addr+R, ACK, MSB, ACK, LSB, NACK, STOP) per Go edge.
module i2c_tmp101_read_sequencer #(
  parameter logic [6:0] SlaveAddress = 7'b1001010,
  parameter logic [3:0] DataBits     = 4'd8
) (
  input  logic        clock,
  input  logic        Reset,
  input  logic        Go,
  input  logic        ClockI2C,
  input  logic        SDAIn,
  input  logic [7:0]  ReceivedData,
  output logic        WriteLoad,
  output logic        ReadorWrite,
  output logic        ShiftorHold,
  output logic        Select,
  output logic        BaudEnable,
  output logic        StartStopAck,
  output logic [7:0]  SentData,
  output logic [15:0] Temperature,
  output logic        Done,
  output logic        Busy,
  output logic        AckError
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_TXADDR, S_ACKADDR, S_READMSB,
    S_MACK, S_READLSB, S_MNACK, S_STOP
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_sclD, r_goD, r_ackBit;
  logic        r_writeLoad, r_rw, r_shift, r_select, r_baud, r_ssa;
  logic        r_done, r_busy, r_ackError;
  logic [15:0] r_temp;

  logic w_rise, w_fall, w_goEdge;

  assign w_rise   = ClockI2C & ~r_sclD;
  assign w_fall   = ~ClockI2C & r_sclD;
  assign w_goEdge = Go & ~r_goD;

  always_ff @(posedge clock) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_sclD      <= 1'b0;
      r_goD       <= 1'b0;
      r_ackBit    <= 1'b0;
      r_writeLoad <= 1'b0;
      r_rw        <= 1'b0;
      r_shift     <= 1'b0;
      r_select    <= 1'b0;
      r_baud      <= 1'b0;
      r_ssa       <= 1'b1;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_ackError  <= 1'b0;
      r_temp      <= '0;
    end else begin
      r_sclD      <= ClockI2C;
      r_goD       <= Go;
      r_writeLoad <= 1'b0;
      r_shift     <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_select <= 1'b0;
          r_ssa    <= 1'b1;
          r_baud   <= 1'b0;
          if (w_goEdge) begin
            r_baud     <= 1'b1;
            r_busy     <= 1'b1;
            r_ackError <= 1'b0;
            r_state    <= S_START;
          end
        end
        // r_ssa doubles as the "START already issued" flag here and in S_STOP
        S_START: begin
          if (w_rise && r_ssa) begin
            r_ssa <= 1'b0;
          end else if (w_fall && !r_ssa) begin
            r_writeLoad <= 1'b1;
            r_select    <= 1'b1;
            r_rw        <= 1'b0;
            r_cnt       <= '0;
            r_state     <= S_TXADDR;
          end
        end
        S_TXADDR: begin
          if (w_fall) begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == DataBits - 4'd1) begin
              r_rw    <= 1'b1;
              r_state <= S_ACKADDR;
            end else begin
              r_shift <= 1'b1;
            end
          end
        end
        S_ACKADDR: begin
          if (w_rise) r_ackBit <= SDAIn;
          if (w_fall) begin
            if (!r_ackBit) begin
              r_cnt   <= '0;
              r_state <= S_READMSB;
            end else begin
              r_ackError <= 1'b1;
              r_select   <= 1'b0;
              r_rw       <= 1'b0;
              r_state    <= S_STOP;
            end
          end
        end
        S_READMSB, S_READLSB: begin
          if (w_rise && r_cnt != DataBits) begin
            r_shift <= 1'b1;
            r_cnt   <= r_cnt + 4'd1;
          end else if (w_fall && r_cnt == DataBits) begin
            r_select <= 1'b0;
            r_rw     <= 1'b0;
            if (r_state == S_READMSB) begin
              r_temp[15:8] <= ReceivedData;
              r_ssa        <= 1'b0;
              r_state      <= S_MACK;
            end else begin
              r_temp[7:0] <= ReceivedData;
              r_ssa       <= 1'b1;
              r_state     <= S_MNACK;
            end
          end
        end
        S_MACK: begin
          if (w_fall) begin
            r_rw    <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_READLSB;
          end
        end
        S_MNACK: begin
          if (w_fall) begin
            r_ssa   <= 1'b0;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          r_select <= 1'b0;
          r_rw     <= 1'b0;
          if (w_rise && !r_ssa) begin
            r_ssa <= 1'b1;
          end else if (w_fall && r_ssa) begin
            r_baud  <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign WriteLoad    = r_writeLoad;
  assign ReadorWrite  = r_rw;
  assign ShiftorHold  = r_shift;
  assign Select       = r_select;
  assign BaudEnable   = r_baud;
  assign StartStopAck = r_ssa;
  assign SentData     = {SlaveAddress, 1'b1};
  assign Temperature  = r_temp;
  assign Done         = r_done;
  assign Busy         = r_busy;
  assign AckError     = r_ackError;

endmodule
